serial_addsub_with_vld: RTL and testbench

SERIAL_ADDSUB_WITH_VLD -- requirements
Module: serial_addsub_with_vld

---
 rtl/serial_arith_pkg.sv | 22 ++
 rtl/serial_digit_adder.sv | 30 +++
 rtl/serial_addsub_with_vld.sv | 142 ++++++++++++++
 tb/tb_serial_addsub_with_vld.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared types for the digit-serial add/subtract datapath.
// Revision    : 1.0  initial release
// ============================================================================
package serial_arith_pkg;

  // Operation latched on the first digit of every word
  typedef enum logic [0:0] {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Word framing state: IDLE means no word is open
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/serial_digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_digit_adder
// Description : Combinational DIGIT_W-bit adder with carry in, carry out and
//               the carry into the MSB (needed for signed overflow).
// Revision    : 1.0  initial release
// ============================================================================
module serial_digit_adder
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               msb_cin
);

  logic [DIGIT_W:0] w_full;

  assign w_full  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
  assign s       = w_full[DIGIT_W-1:0];
  assign cout    = w_full[DIGIT_W];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out by XOR.
  assign msb_cin = w_full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b[DIGIT_W-1];

endmodule : serial_digit_adder
`default_nettype wire

// File: rtl/serial_addsub_with_vld.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_with_vld
// Description : Digit-serial (LSB first) adder/subtractor with valid framing,
//               word termination on last or at MAX_DIGITS, registered outputs.
// Revision    : 1.0  initial release
// ============================================================================
module serial_addsub_with_vld
  import serial_arith_pkg::*;
#(
  parameter  int DIGIT_W    = 4,
  parameter  int MAX_DIGITS = 16,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               last,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic               err_len
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  // Word state
  state_e             r_state,  w_state_nxt;
  op_e                r_op,     w_op_nxt;
  logic               r_carry,  w_carry_nxt;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;

  // Digit datapath
  op_e                w_op_cur;
  logic               w_cin;
  logic [CNT_W-1:0]   w_idx;
  logic               w_term;
  logic [DIGIT_W-1:0] w_b_eff;
  logic [DIGIT_W-1:0] w_s;
  logic               w_cout;
  logic               w_msb_cin;

  // Next values of the registered outputs
  logic               w_out_vld_nxt;
  logic [DIGIT_W-1:0] w_sum_nxt;
  logic               w_out_last_nxt;
  logic               w_carry_out_nxt;
  logic               w_overflow_nxt;
  logic [CNT_W-1:0]   w_digit_cnt_nxt;
  logic               w_err_len_nxt;

  // A word's first digit takes op from sub; carry-in of 1 forms the two's complement.
  assign w_op_cur = (r_state == IDLE) ? op_e'(sub) : r_op;
  assign w_cin    = (r_state == IDLE) ? (w_op_cur == OP_SUB) : r_carry;
  assign w_idx    = (r_state == IDLE) ? C_ONE : (r_cnt + C_ONE);
  assign w_term   = vld && (last || (w_idx == C_MAX));
  assign w_b_eff  = b ^ {DIGIT_W{w_op_cur == OP_SUB}};

  serial_digit_adder #(
    .DIGIT_W (DIGIT_W)
  ) u_adder (
    .a       (a),
    .b       (w_b_eff),
    .cin     (w_cin),
    .s       (w_s),
    .cout    (w_cout),
    .msb_cin (w_msb_cin)
  );

  // Next-state and next-output decode; idle cycles hold word state and the data outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_carry_nxt     = r_carry;
    w_cnt_nxt       = r_cnt;
    w_out_vld_nxt   = 1'b0;
    w_sum_nxt       = sum;
    w_out_last_nxt  = 1'b0;
    w_carry_out_nxt = 1'b0;
    w_overflow_nxt  = 1'b0;
    w_digit_cnt_nxt = digit_cnt;
    w_err_len_nxt   = 1'b0;

    if (vld) begin
      w_out_vld_nxt   = 1'b1;
      w_sum_nxt       = w_s;
      w_digit_cnt_nxt = w_idx;
      w_op_nxt        = w_op_cur;
      if (w_term) begin
        w_state_nxt     = IDLE;
        w_carry_nxt     = 1'b0;
        w_cnt_nxt       = '0;
        w_out_last_nxt  = 1'b1;
        w_carry_out_nxt = w_cout;
        w_overflow_nxt  = w_msb_cin ^ w_cout;
        w_err_len_nxt   = ~last;
      end else begin
        w_state_nxt = BUSY;
        w_carry_nxt = w_cout;
        w_cnt_nxt   = w_idx;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= OP_ADD;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      out_vld   <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      digit_cnt <= '0;
      err_len   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_carry   <= w_carry_nxt;
      r_cnt     <= w_cnt_nxt;
      out_vld   <= w_out_vld_nxt;
      sum       <= w_sum_nxt;
      out_last  <= w_out_last_nxt;
      carry_out <= w_carry_out_nxt;
      overflow  <= w_overflow_nxt;
      digit_cnt <= w_digit_cnt_nxt;
      err_len   <= w_err_len_nxt;
    end
  end

endmodule : serial_addsub_with_vld
`default_nettype wire

// File: tb/tb_serial_addsub_with_vld.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub_with_vld
// Description : Bench for serial_addsub_with_vld; two instances (MAX_DIGITS 16
//               and 2) share stimulus and are checked against a word-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_addsub_with_vld;

  localparam int W = 4;
  localparam int MAXD [2] = '{16, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic last = 1'b0;

  logic         d1_vld, d1_last, d1_co, d1_ov, d1_err;
  logic [W-1:0] d1_sum;
  logic [4:0]   d1_dc;
  logic         d2_vld, d2_last, d2_co, d2_ov, d2_err;
  logic [W-1:0] d2_sum;
  logic [1:0]   d2_dc;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  serial_addsub_with_vld #(.DIGIT_W(W), .MAX_DIGITS(16)) u_dut1 (
    .clk(clk), .rst(rst), .vld(vld), .sub(sub), .a(a), .b(b), .last(last),
    .out_vld(d1_vld), .sum(d1_sum), .out_last(d1_last), .carry_out(d1_co),
    .overflow(d1_ov), .digit_cnt(d1_dc), .err_len(d1_err));

  serial_addsub_with_vld #(.DIGIT_W(W), .MAX_DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .vld(vld), .sub(sub), .a(a), .b(b), .last(last),
    .out_vld(d2_vld), .sum(d2_sum), .out_last(d2_last), .carry_out(d2_co),
    .overflow(d2_ov), .digit_cnt(d2_dc), .err_len(d2_err));

  // Word-level model: whole operands accumulated, result from plain arithmetic
  bit           m_open [2];
  bit           m_op   [2];
  int           m_k    [2];
  logic [127:0] m_A    [2];
  logic [127:0] m_B    [2];
  logic         e_vld  [2];
  logic [W-1:0] e_sum  [2];
  logic         e_last [2];
  logic         e_co   [2];
  logic         e_ov   [2];
  logic [7:0]   e_dc   [2];
  logic         e_err  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_step(input int i);
    logic [127:0]        mask, r;
    logic signed [127:0] sa, sb, res, lim;
    int                  n;
    bit                  term;
    if (rst) begin
      m_open[i] = 0; m_op[i] = 0; m_k[i] = 0; m_A[i] = '0; m_B[i] = '0;
      e_vld[i] = 0; e_sum[i] = '0; e_last[i] = 0; e_co[i] = 0; e_ov[i] = 0;
      e_dc[i] = '0; e_err[i] = 0;
      return;
    end
    e_vld[i] = vld; e_last[i] = 0; e_co[i] = 0; e_ov[i] = 0; e_err[i] = 0;
    if (!vld) return;
    if (!m_open[i]) begin
      m_open[i] = 1; m_op[i] = sub; m_k[i] = 0; m_A[i] = '0; m_B[i] = '0;
    end
    m_k[i]++;
    n = W * m_k[i];
    m_A[i] = m_A[i] | (128'(a) << (n - W));
    m_B[i] = m_B[i] | (128'(b) << (n - W));
    mask = (128'd1 << n) - 128'd1;
    r = m_op[i] ? (m_A[i] + ((~m_B[i]) & mask) + 128'd1) : (m_A[i] + m_B[i]);
    e_sum[i] = r[n-1 -: W];
    e_dc[i]  = 8'(m_k[i]);
    term = last || (m_k[i] == MAXD[i]);
    if (term) begin
      sa = $signed(m_A[i]);
      sb = $signed(m_B[i]);
      if (m_A[i][n-1]) sa = sa - (128'sd1 <<< n);
      if (m_B[i][n-1]) sb = sb - (128'sd1 <<< n);
      res = m_op[i] ? (sa - sb) : (sa + sb);
      lim = 128'sd1 <<< (n - 1);
      e_last[i] = 1;
      e_co[i]   = r[n];
      e_ov[i]   = (res >= lim) || (res < -lim);
      e_err[i]  = !last;
      m_open[i] = 0;
    end
  endfunction

  // Advance the model on the same edge the DUT samples its inputs
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic cmp_inst(input int i, input logic v, input logic [W-1:0] s, input logic l,
                          input logic co, input logic ov, input logic [7:0] dc, input logic err);
    check($sformatf("dut%0d.out_vld", i+1),   32'(v),   32'(e_vld[i]));
    check($sformatf("dut%0d.sum", i+1),       32'(s),   32'(e_sum[i]));
    check($sformatf("dut%0d.out_last", i+1),  32'(l),   32'(e_last[i]));
    check($sformatf("dut%0d.carry_out", i+1), 32'(co),  32'(e_co[i]));
    check($sformatf("dut%0d.overflow", i+1),  32'(ov),  32'(e_ov[i]));
    check($sformatf("dut%0d.digit_cnt", i+1), 32'(dc),  32'(e_dc[i]));
    check($sformatf("dut%0d.err_len", i+1),   32'(err), 32'(e_err[i]));
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, d1_vld, d1_sum, d1_last, d1_co, d1_ov, 8'(d1_dc), d1_err);
      cmp_inst(1, d2_vld, d2_sum, d2_last, d2_co, d2_ov, 8'(d2_dc), d2_err);
    end
  end

  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [W-1:0] av, input logic [W-1:0] bv, input logic l);
    @(negedge clk);
    rst = r; vld = v; sub = s; a = av; b = bv; last = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last_pct;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    check("reset out_vld",   32'(d1_vld), 0);
    check("reset sum",       32'(d1_sum), 0);
    check("reset digit_cnt", 32'(d1_dc),  0);
    check("reset out_last",  32'(d1_last), 0);

    // 0x12 + 0x0F
    drive(0, 1, 0, 4'h2, 4'hF, 0);
    check("add d1 sum", 32'(d1_sum), 32'h1);
    check("add d1 cnt", 32'(d1_dc), 1);
    check("add d1 last", 32'(d1_last), 0);
    drive(0, 1, 0, 4'h1, 4'h0, 1);
    check("add d2 sum", 32'(d1_sum), 32'h2);
    check("add d2 last", 32'(d1_last), 1);
    check("add d2 co", 32'(d1_co), 0);
    check("add d2 ov", 32'(d1_ov), 0);
    check("add d2 cnt", 32'(d1_dc), 2);

    // 0x10 - 0x01
    drive(0, 1, 1, 4'h0, 4'h1, 0);
    check("sub d1 sum", 32'(d1_sum), 32'hF);
    drive(0, 1, 1, 4'h1, 4'h0, 1);
    check("sub d2 sum", 32'(d1_sum), 32'h0);
    check("sub d2 co", 32'(d1_co), 1);
    check("sub d2 ov", 32'(d1_ov), 0);

    // single-digit 7 + 1
    drive(0, 1, 0, 4'h7, 4'h1, 1);
    check("single sum", 32'(d1_sum), 32'h8);
    check("single last", 32'(d1_last), 1);
    check("single co", 32'(d1_co), 0);
    check("single ov", 32'(d1_ov), 1);
    check("single cnt", 32'(d1_dc), 1);

    // gap inside a word; sub on the 2nd digit is ignored
    drive(0, 1, 0, 4'h2, 4'hF, 0);
    drive(0, 0, 1, 4'h9, 4'h9, 1);
    check("gap out_vld", 32'(d1_vld), 0);
    check("gap sum hold", 32'(d1_sum), 32'h1);
    drive(0, 1, 1, 4'h1, 4'h0, 1);
    check("gap d2 sum", 32'(d1_sum), 32'h2);
    check("gap d2 co", 32'(d1_co), 0);
    check("gap d2 last", 32'(d1_last), 1);

    // forced termination at MAX_DIGITS=2 on the second instance
    drive(0, 1, 0, 4'h0, 4'h0, 0);
    drive(0, 1, 0, 4'h0, 4'h0, 0);
    check("force last", 32'(d2_last), 1);
    check("force err", 32'(d2_err), 1);
    drive(0, 1, 0, 4'h0, 4'h0, 0);
    check("force next cnt", 32'(d2_dc), 1);
    check("force next err", 32'(d2_err), 0);
    drive(0, 1, 0, 4'h0, 4'h0, 1);

    // reset discards an open word carrying 1
    drive(0, 1, 0, 4'hF, 4'h1, 0);
    drive(1, 1, 0, 4'h3, 4'h3, 1);
    check("rst out_vld", 32'(d1_vld), 0);
    check("rst sum", 32'(d1_sum), 0);
    check("rst last", 32'(d1_last), 0);
    check("rst cnt", 32'(d1_dc), 0);
    drive(0, 1, 0, 4'h1, 4'h1, 1);
    check("post-rst sum", 32'(d1_sum), 32'h2);
    check("post-rst co", 32'(d1_co), 0);

    // randomized traffic with varying word lengths
    last_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) last_pct = (c % 1500 == 0) ? 30 : ((c % 1000 == 0) ? 3 : 10);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
            4'($urandom), 4'($urandom), ($urandom_range(0, 99) < last_pct));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule : tb_serial_addsub_with_vld
`default_nettype wire
